// File: rtl/frame_buffer_pkg.sv
// rtl/frame_buffer_pkg.sv - shared types and default geometry for the double-buffered frame buffer
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_t;

  localparam int FB_PIX_W = 4;
  localparam int FB_H_RES = 320;
  localparam int FB_V_RES = 240;

endpackage

// File: rtl/fb_bank.sv
// rtl/fb_bank.sv - one DEPTH x PIX_W pixel bank, sync write, registered read (0 when out of range)
module fb_bank #(
  parameter int PIX_W  = 4,
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // The caller only raises we for in-range addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if ({1'b0, raddr} < DEPTH_EXT) begin
      rdata_q <= mem_q[raddr];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// rtl/frame_buffer_dbl.sv - double-buffered frame buffer: GPU draws/clears back bank, VGA reads front, swap in vblank
module frame_buffer_dbl
  import frame_buffer_pkg::*;
#(
  parameter int PIX_W = FB_PIX_W,
  parameter int H_RES = FB_H_RES,
  parameter int V_RES = FB_V_RES,
  localparam int DEPTH  = H_RES * V_RES,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              gpu_clk,
  input  logic              gpu_rst_n,
  input  logic [PIX_W-1:0]  gpu_pixel_data,
  input  logic [ADDR_W-1:0] gpu_pixel_addr,
  input  logic              gpu_we,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  input  logic              swap_req,
  input  logic              vga_vblank,
  output logic              gpu_busy,
  output logic              swap_done,
  output logic              front_sel,
  input  logic [ADDR_W-1:0] vga_pixel_addr,
  output logic [PIX_W-1:0]  vga_pixel_data
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [PIX_W-1:0]  clr_color_q, clr_color_d;
  logic              front_sel_q, front_sel_d;
  logic              swap_done_q, swap_done_d;
  logic              rd_sel_q;

  logic              back_we;
  logic [ADDR_W-1:0] back_waddr;
  logic [PIX_W-1:0]  back_wdata;
  logic              gpu_addr_ok;
  logic [PIX_W-1:0]  rdata0, rdata1;

  assign gpu_addr_ok = ({1'b0, gpu_pixel_addr} < DEPTH_EXT);

  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      front_sel_q <= front_sel_d;
      swap_done_q <= swap_done_d;
      rd_sel_q    <= front_sel_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    back_we     = 1'b0;
    back_waddr  = gpu_pixel_addr;
    back_wdata  = gpu_pixel_data;
    case (state_q)
      IDLE: begin
        back_we = gpu_we && gpu_addr_ok;
        // A clear request in the same cycle as a swap request wins; the swap is lost.
        if (clear_req) begin
          state_d     = CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        back_we    = 1'b1;
        back_waddr = clr_addr_q;
        back_wdata = clr_color_q;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (vga_vblank) begin
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Back bank is bank[~front_sel]; front bank is never written.
  fb_bank #(.PIX_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (gpu_clk),
    .rst_n (gpu_rst_n),
    .we    (back_we && front_sel_q),
    .waddr (back_waddr),
    .wdata (back_wdata),
    .raddr (vga_pixel_addr),
    .rdata (rdata0)
  );

  fb_bank #(.PIX_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (gpu_clk),
    .rst_n (gpu_rst_n),
    .we    (back_we && !front_sel_q),
    .waddr (back_waddr),
    .wdata (back_wdata),
    .raddr (vga_pixel_addr),
    .rdata (rdata1)
  );

  assign vga_pixel_data = rd_sel_q ? rdata1 : rdata0;
  assign gpu_busy       = (state_q != IDLE);
  assign swap_done      = swap_done_q;
  assign front_sel      = front_sel_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// tb/tb_frame_buffer_dbl.sv - self-checking bench for frame_buffer_dbl against a behavioural bank model
module tb_frame_buffer_dbl;

  localparam int PIX_W  = 4;
  localparam int H_RES  = 20;
  localparam int V_RES  = 10;
  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              gpu_clk = 1'b0;
  logic              gpu_rst_n = 1'b0;
  logic [PIX_W-1:0]  gpu_pixel_data = '0;
  logic [ADDR_W-1:0] gpu_pixel_addr = '0;
  logic              gpu_we = 1'b0;
  logic              clear_req = 1'b0;
  logic [PIX_W-1:0]  clear_color = '0;
  logic              swap_req = 1'b0;
  logic              vga_vblank = 1'b0;
  logic              gpu_busy;
  logic              swap_done;
  logic              front_sel;
  logic [ADDR_W-1:0] vga_pixel_addr = '1;
  logic [PIX_W-1:0]  vga_pixel_data;

  frame_buffer_dbl #(.PIX_W(PIX_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .gpu_clk        (gpu_clk),
    .gpu_rst_n      (gpu_rst_n),
    .gpu_pixel_data (gpu_pixel_data),
    .gpu_pixel_addr (gpu_pixel_addr),
    .gpu_we         (gpu_we),
    .clear_req      (clear_req),
    .clear_color    (clear_color),
    .swap_req       (swap_req),
    .vga_vblank     (vga_vblank),
    .gpu_busy       (gpu_busy),
    .swap_done      (swap_done),
    .front_sel      (front_sel),
    .vga_pixel_addr (vga_pixel_addr),
    .vga_pixel_data (vga_pixel_data)
  );

  always #5 gpu_clk = ~gpu_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: two banks as plain arrays, a clear countdown and a pending-swap flag.
  int mem_m [2][DEPTH];
  int front_m   = 0;
  int clr_left  = 0;
  int clr_pos   = 0;
  int clr_col   = 0;
  bit swap_pend = 1'b0;
  int exp_data  = 0;
  int exp_done  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    front_m   = 0;
    clr_left  = 0;
    clr_pos   = 0;
    swap_pend = 1'b0;
    exp_data  = 0;
    exp_done  = 0;
  endfunction

  function automatic void model_step();
    int ra;
    int back;
    ra = int'(vga_pixel_addr);
    exp_data = (ra < DEPTH) ? mem_m[front_m][ra] : 0;
    exp_done = 0;
    back = 1 - front_m;
    if (clr_left > 0) begin
      mem_m[back][clr_pos] = clr_col;
      clr_pos++;
      clr_left--;
    end else if (swap_pend) begin
      if (vga_vblank) begin
        front_m   = back;
        exp_done  = 1;
        swap_pend = 1'b0;
      end
    end else begin
      if (gpu_we && int'(gpu_pixel_addr) < DEPTH)
        mem_m[back][int'(gpu_pixel_addr)] = int'(gpu_pixel_data);
      if (clear_req) begin
        clr_left = DEPTH;
        clr_pos  = 0;
        clr_col  = int'(clear_color);
      end else if (swap_req) begin
        swap_pend = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge gpu_clk);
    @(negedge gpu_clk);
    check("busy", gpu_busy, (clr_left > 0 || swap_pend) ? 1 : 0);
    check("front_sel", front_sel, front_m);
    check("swap_done", swap_done, exp_done);
    check("rd_data", vga_pixel_data, exp_data);
  endtask

  task automatic run_clear(input int color, input bit rand_rd);
    int n;
    clear_req   = 1'b1;
    clear_color = PIX_W'(color);
    tick();
    clear_req = 1'b0;
    n = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (!gpu_busy) break;
      n++;
      if (rand_rd) vga_pixel_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      tick();
    end
    check("clear_len", n, DEPTH);
  endtask

  task automatic do_swap();
    swap_req   = 1'b1;
    vga_vblank = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    vga_vblank = 1'b0;
  endtask

  task automatic apply_reset();
    #2 gpu_rst_n = 1'b0;
    #1;
    check("rst_busy", gpu_busy, 0);
    check("rst_done", swap_done, 0);
    check("rst_front", front_sel, 0);
    check("rst_data", vga_pixel_data, 0);
    model_reset();
    @(posedge gpu_clk);
    @(negedge gpu_clk);
    gpu_rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int front_before;

    // Reset and initialise both banks to known contents.
    repeat (3) @(negedge gpu_clk);
    check("rst_busy", gpu_busy, 0);
    check("rst_front", front_sel, 0);
    check("rst_done", swap_done, 0);
    check("rst_data", vga_pixel_data, 0);
    gpu_rst_n = 1'b1;
    model_reset();
    run_clear(0, 1'b0);
    do_swap();
    run_clear(0, 1'b0);

    // Write 0xA at back address 5, swap, read it back.
    gpu_we = 1'b1; gpu_pixel_addr = 5; gpu_pixel_data = 4'hA;
    tick();
    gpu_we = 1'b0;
    do_swap();
    vga_pixel_addr = 5;
    tick();
    check("wr_rd_a5", vga_pixel_data, 4'hA);

    // Swap waits through 10 cycles of active video, fires on first vblank, once.
    front_before = front_m;
    swap_req = 1'b1; vga_vblank = 1'b0;
    tick();
    swap_req = 1'b0;
    repeat (10) tick();
    check("swap_wait_busy", gpu_busy, 1);
    vga_vblank = 1'b1;
    tick();
    check("swap_pulse", swap_done, 1);
    check("swap_toggle", front_sel, 1 - front_before);
    pulses = 0;
    repeat (4) begin
      tick();
      pulses += swap_done;
    end
    check("vblank_single", pulses, 0);
    vga_vblank = 1'b0;

    // Clear to 3 while sweeping the front bank, then show the cleared bank.
    run_clear(3, 1'b1);
    do_swap();
    for (int a = 0; a < DEPTH; a++) begin
      vga_pixel_addr = ADDR_W'(a);
      tick();
      if (a % 40 == 7) check("clear3_rd", vga_pixel_data, 3);
    end

    // Clear and swap requested together: clear runs, swap dropped, GPU writes dropped.
    front_before = front_m;
    clear_req = 1'b1; swap_req = 1'b1; clear_color = 4'h7;
    tick();
    clear_req = 1'b0; swap_req = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      gpu_we = 1'b1;
      gpu_pixel_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      gpu_pixel_data = PIX_W'($urandom);
      vga_vblank = ($urandom % 3 == 0);
      tick();
    end
    gpu_we = 1'b0; vga_vblank = 1'b1;
    repeat (3) tick();
    check("contention_noswap", front_sel, front_before);
    vga_vblank = 1'b0;

    // Out-of-range write/read.
    gpu_we = 1'b1; gpu_pixel_addr = ADDR_W'(DEPTH); gpu_pixel_data = 4'hF;
    vga_pixel_addr = ADDR_W'(DEPTH);
    tick();
    gpu_we = 1'b0;
    tick();
    check("oob_rd", vga_pixel_data, 0);

    // Reset part way through a clear (clr_addr=100): partial fill, no swap.
    clear_req = 1'b1; clear_color = 4'h9;
    tick();
    clear_req = 1'b0;
    repeat (100) tick();
    apply_reset();
    tick();
    check("post_rst_busy", gpu_busy, 0);
    do_swap();
    for (int a = 90; a < 110; a++) begin
      vga_pixel_addr = ADDR_W'(a);
      tick();
    end

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      gpu_we         = $urandom % 2;
      gpu_pixel_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      gpu_pixel_data = PIX_W'($urandom);
      clear_req      = ($urandom % 60 == 0);
      clear_color    = PIX_W'($urandom);
      swap_req       = ($urandom % 6 == 0);
      vga_vblank     = ($urandom % 4 == 0);
      vga_pixel_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      tick();
      if (i == 1500) begin
        gpu_we = 1'b0;
        apply_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
